sram_bank_ctrl: RTL
===================

Name: sram_bank_ctrl

Overview:
Parametrised, byte-maskable single-port SRAM bank with a valid/ready request channel and a backpressured read-response channel, for the iDMA/iNoC buffer path.
- Unlike a bare array, it preserves unstrobed bytes on partial writes.
- Flags out-of-range addresses.
- Zero-fills itself after reset and on request.
- Buffers read data so the consumer may stall.

Parameters:
DATA_W, 128, data width in bits; must be a multiple of 8
DEPTH, 24576, number of words; need not be a power of two
ADDR_W, 15, address width; 2**ADDR_W >= DEPTH
STRB_W (localparam), DATA_W/8, byte-strobe width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_wen  in  1  1=write, 0=read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_wstrb  in  STRB_W  byte enables; bit i covers wdata[8i+7:8i]
rsp_valid  out  1  read response valid
rsp_ready  in  1  consumer ready
rsp_rdata  out  DATA_W  read data
rsp_err  out  1  response belongs to an out-of-range read
clr_start  in  1  pulse: start zero-fill
busy  out  1  zero-fill in progress
clr_done  out  1  one-cycle pulse at end of zero-fill

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-low reset, rst_n, sampled on the rising edge of clk.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1, clr_done=0. The response buffer is emptied and the credit count is 0. The FSM enters CLEAR with clr_ptr=0.
- FSM states: CLEAR and RUN.
  - CLEAR: writes all-zero to mem[clr_ptr], one word per cycle, and increments clr_ptr. After writing DEPTH-1 it goes to RUN, with clr_done=1 for one cycle and busy=0.
  - RUN: clr_start=1 moves to CLEAR with clr_ptr=0 and busy=1 from the next cycle. clr_start is ignored in CLEAR.
  - Zero-fill takes exactly DEPTH cycles. Reset during CLEAR restarts it from 0.
- req_ready = (state==RUN) && !clr_start && (credits<2 || rsp_pop).
  - rsp_pop = rsp_valid && rsp_ready.
  - Writes and reads share the same req_ready.
- Write (accepted, req_wen=1, req_addr<DEPTH): at the accepting edge, each byte with wstrb=1 takes wdata and each byte with wstrb=0 keeps its old value.
  - wstrb=0 is accepted and has no effect.
  - A write with req_addr>=DEPTH is dropped silently.
  - Writes produce no response.
- Read (accepted, req_wen=0): mem is read at the accepting edge and the result enters a 2-entry response FIFO one cycle later.
  - Read latency = 1: rsp_valid can be 1 in the cycle after acceptance.
  - Out-of-range reads return rsp_rdata=0 with rsp_err=1.
  - Responses are returned in order.
- Credits:
  - +1 on read accept, -1 on rsp_pop, unchanged when both happen in the same cycle.
  - Credits never exceed 2, so the FIFO never overflows and no response is lost under any rsp_ready pattern.
- rsp_rdata and rsp_err hold stable while rsp_valid && !rsp_ready.
- Read-after-write to the same address in the next cycle returns the merged new data. No bypass is needed because there is a single port.
- Responses to reads accepted before a CLEAR still drain during CLEAR and carry pre-clear data.
- Memory contents have no reset; zero-fill provides initial state.

Optional Feature:
- Macro: SRAM_BANK_OUT_REG_EN.
- Defined:
  - An extra output register stage after the array; read latency becomes 2.
  - The response FIFO and credit limit grow to 3. req_ready uses credits<3.
  - All other rules are unchanged.
- Undefined:
  - Latency 1, credit limit 2, as above.

Test Plan:
1. Reset, then hold rst_n=1 -> busy=1 for exactly DEPTH cycles, then clr_done pulses once, busy=0, req_ready=1; read addr 5 returns 0 with rsp_err=0.
2. Write addr 3 with wdata=all-0xAA, wstrb=all-1; then write addr 3 with wdata=all-0x55, wstrb=16'h000F; read addr 3 -> low 4 bytes 0x55, upper 12 bytes 0xAA, one cycle after accept (two with SRAM_BANK_OUT_REG_EN).
3. Hold rsp_ready=0 and issue reads to 1, 2, 3 back-to-back -> two accepted, req_ready=0; release rsp_ready -> data 1, 2, 3 delivered in order with no loss, and rsp_rdata stable while stalled.
4. Read addr DEPTH (24576) -> rsp_rdata=0, rsp_err=1; write addr DEPTH, then read addr 0 -> contents unchanged.
5. Fill addr 7 with nonzero data, then pulse clr_start together with req_valid -> request not accepted, busy=1 next cycle; after clr_done, read addr 7 returns 0.
6. Assert rst_n=0 for one cycle mid-CLEAR at clr_ptr=100 -> rsp_valid=0, and the clear restarts, lasting DEPTH cycles from that reset.

Source files
------------

// File: rtl/sram_bank_ctrl.sv
// Byte-maskable single-port SRAM bank: valid/ready requests, zero-fill sequencer, credit-limited read FIFO.
// Optional macro SRAM_BANK_OUT_REG_EN inserts an output register after the array (read latency 2, 3 credits).
module sram_bank_ctrl #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 24576,
    parameter int ADDR_W = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  clr_done
);

    localparam int STRB_W = DATA_W / 8;
`ifdef SRAM_BANK_OUT_REG_EN
    localparam int FIFO_D = 3;
`else
    localparam int FIFO_D = 2;
`endif
    localparam int CNT_W = 2;
    localparam int PTR_W = $clog2(FIFO_D);
    localparam logic [CNT_W-1:0]  CRED_MAX  = CNT_W'(FIFO_D);
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_D - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   clr_ptr_r;
    logic                busy_r;
    logic                clr_done_r;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [CNT_W-1:0]    credits_r;
    logic [CNT_W-1:0]    fifo_cnt_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [DATA_W-1:0]   fifo_data_r [FIFO_D];
    logic                fifo_err_r  [FIFO_D];

    logic                rsp_valid_s;
    logic                rsp_pop_s;
    logic                req_ready_s;
    logic                rd_acc_s;
    logic                wr_acc_s;
    logic                in_range_s;
    logic [DATA_W-1:0]   rd_data_s;
    logic                push_s;
    logic [DATA_W-1:0]   push_data_s;
    logic                push_err_s;

    // Handshake decode, address range check and array read for the current request
    always_comb begin
        rsp_valid_s = (fifo_cnt_r != {CNT_W{1'b0}});
        rsp_pop_s   = rsp_valid_s && rsp_ready;
        req_ready_s = rst_n && (state_r == RUN) && !clr_start &&
                      ((credits_r < CRED_MAX) || rsp_pop_s);
        rd_acc_s    = req_valid && req_ready_s && !req_wen;
        wr_acc_s    = req_valid && req_ready_s && req_wen;
        in_range_s  = ({1'b0, req_addr} < DEPTH_V);
        if (in_range_s) begin
            rd_data_s = mem[req_addr];
        end else begin
            rd_data_s = {DATA_W{1'b0}};
        end
    end

`ifdef SRAM_BANK_OUT_REG_EN
    logic                pipe_vld_r;
    logic                pipe_err_r;
    logic [DATA_W-1:0]   pipe_data_r;

    // Output register stage between the array read and the response FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld_r  <= 1'b0;
            pipe_err_r  <= 1'b0;
            pipe_data_r <= {DATA_W{1'b0}};
        end else begin
            pipe_vld_r  <= rd_acc_s;
            pipe_err_r  <= !in_range_s;
            pipe_data_r <= rd_data_s;
        end
    end

    assign push_s      = pipe_vld_r;
    assign push_data_s = pipe_data_r;
    assign push_err_s  = pipe_err_r;
`else
    assign push_s      = rd_acc_s;
    assign push_data_s = rd_data_s;
    assign push_err_s  = !in_range_s;
`endif

    // Array write port: zero-fill while clearing, otherwise byte-merged request writes
    always_ff @(posedge clk) begin
        if (state_r == CLEAR) begin
            mem[clr_ptr_r] <= {DATA_W{1'b0}};
        end else if (wr_acc_s && in_range_s) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (req_wstrb[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Zero-fill sequencer: CLEAR walks every word once, RUN serves requests
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= CLEAR;
            clr_ptr_r  <= {ADDR_W{1'b0}};
            busy_r     <= 1'b1;
            clr_done_r <= 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    if (clr_ptr_r == LAST_ADDR) begin
                        state_r    <= RUN;
                        clr_ptr_r  <= {ADDR_W{1'b0}};
                        busy_r     <= 1'b0;
                        clr_done_r <= 1'b1;
                    end else begin
                        clr_ptr_r  <= clr_ptr_r + ADDR_W'(1);
                        busy_r     <= 1'b1;
                        clr_done_r <= 1'b0;
                    end
                end
                RUN: begin
                    clr_done_r <= 1'b0;
                    if (clr_start) begin
                        state_r   <= CLEAR;
                        clr_ptr_r <= {ADDR_W{1'b0}};
                        busy_r    <= 1'b1;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= CLEAR;
                    clr_ptr_r  <= {ADDR_W{1'b0}};
                    busy_r     <= 1'b1;
                    clr_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Response FIFO and credit counter; credits cover every read not yet popped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits_r  <= {CNT_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            for (int i = 0; i < FIFO_D; i++) begin
                fifo_data_r[i] <= {DATA_W{1'b0}};
                fifo_err_r[i]  <= 1'b0;
            end
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= push_data_s;
                fifo_err_r[wr_ptr_r]  <= push_err_s;
                wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
            end
            if (rsp_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, rsp_pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            case ({rd_acc_s, rsp_pop_s})
                2'b10:   credits_r <= credits_r + CNT_W'(1);
                2'b01:   credits_r <= credits_r - CNT_W'(1);
                default: credits_r <= credits_r;
            endcase
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_s;
    assign rsp_rdata = fifo_data_r[rd_ptr_r];
    assign rsp_err   = fifo_err_r[rd_ptr_r];
    assign busy      = busy_r;
    assign clr_done  = clr_done_r;

endmodule
